// File: rtl/switchable_register_bank_if.sv
// rtl/switchable_register_bank_if.sv - select/op/data and read-port bundle for switchable_register_bank
interface switchable_register_bank_if #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0]       SR;
  logic [1:0]                OP;
  logic [WIDTH-1:0]          S_bus;
  logic [AW-1:0]             RA_SEL;
  logic [AW-1:0]             RB_SEL;
  logic [WIDTH-1:0]          A_bus;
  logic [WIDTH-1:0]          B_bus;
  logic [NUM_REGS*WIDTH-1:0] Q_all;
  logic                      WRAP;

  modport master (
    output SR, OP, S_bus, RA_SEL, RB_SEL,
    input  A_bus, B_bus, Q_all, WRAP
  );

  modport slave (
    input  SR, OP, S_bus, RA_SEL, RB_SEL,
    output A_bus, B_bus, Q_all, WRAP
  );
endinterface

// File: rtl/switchable_register_bank.sv
// rtl/switchable_register_bank.sv - bank of load/inc/dec/zero registers with two read ports; optional SWITCHABLE_REGISTER_BANK_BYPASS_EN
module switchable_register_bank #(
  parameter int WIDTH      = 16,
  parameter int NUM_REGS   = 8,
  parameter int INIT_VALUE = 0
) (
  input  logic                       CLK,
  input  logic                       CLR,
  switchable_register_bank_if.slave  bus
);
  localparam int               AW       = $clog2(NUM_REGS);
  localparam logic [WIDTH-1:0] INIT     = WIDTH'(INIT_VALUE);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [1:0]       OP_LOAD  = 2'b00;
  localparam logic [1:0]       OP_INC   = 2'b01;
  localparam logic [1:0]       OP_DEC   = 2'b10;

  logic [WIDTH-1:0] r_regs [NUM_REGS];
  logic             r_wrap;
  logic [WIDTH-1:0] w_next [NUM_REGS];
  logic             w_wrap;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

  // Next value of every register and whether any selected counter wraps this edge
  always_comb begin
    w_wrap = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_next[i] = r_regs[i];
      if (bus.SR[i]) begin
        case (bus.OP)
          OP_LOAD: w_next[i] = bus.S_bus;
          OP_INC: begin
            w_next[i] = r_regs[i] + WIDTH'(1);
            if (r_regs[i] == ALL_ONES) w_wrap = 1'b1;
          end
          OP_DEC: begin
            w_next[i] = r_regs[i] - WIDTH'(1);
            if (r_regs[i] == '0) w_wrap = 1'b1;
          end
          default: w_next[i] = '0;
        endcase
      end
    end
  end

  // Register storage and wrap flag; CLR clears immediately, independent of CLK
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= INIT;
      r_wrap <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= w_next[i];
      r_wrap <= w_wrap;
    end
  end

  // Read ports: stored value of the selected register, zero for an index past the bank
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.RA_SEL == AW'(i)) w_a = r_regs[i];
      if (bus.RB_SEL == AW'(i)) w_b = r_regs[i];
    end
`ifdef SWITCHABLE_REGISTER_BANK_BYPASS_EN
    // Forward S_bus when the selected register is being loaded this cycle
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.RA_SEL == AW'(i) && bus.SR[i] && bus.OP == OP_LOAD) w_a = bus.S_bus;
      if (bus.RB_SEL == AW'(i) && bus.SR[i] && bus.OP == OP_LOAD) w_b = bus.S_bus;
    end
`endif
  end

  assign bus.A_bus = w_a;
  assign bus.B_bus = w_b;
  assign bus.WRAP  = r_wrap;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q_all
    assign bus.Q_all[g*WIDTH +: WIDTH] = r_regs[g];
  end
endmodule
